// File: rtl/sprite_rom_arbiter_if.sv
`timescale 1ns/1ps
// Bus between the sprite engines, the sprite ROM and the ROM arbiter.
// master = requesters/ROM side, slave = arbiter.
interface sprite_rom_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 4
);
  logic                        en;
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*ADDR_W-1:0]   addr_flat;
  logic [NUM_REQ-1:0]          gnt;
  logic [ADDR_W-1:0]           rom_addr;
  logic [DATA_W-1:0]           rom_q;
  logic [DATA_W-1:0]           rdata;
  logic [NUM_REQ-1:0]          rvalid;
  logic                        busy;

  modport master (
    output en, req, addr_flat, rom_q,
    input  gnt, rom_addr, rdata, rvalid, busy
  );

  modport slave (
    input  en, req, addr_flat, rom_q,
    output gnt, rom_addr, rdata, rvalid, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one synchronous sprite ROM among NUM_REQ sprite engines.
// Define SPRITE_ARB_PRIO_EN to give requester 0 (player) strict priority over the round-robin.
module sprite_rom_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                vga_clk,
  input  logic                reset_n,
  sprite_rom_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] id;
  } tag_t;

  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   win_c;
  logic [IDX_W-1:0]   cand_c;
  logic               hit_c;
  logic               ptr_upd_c;
  logic [NUM_REQ-1:0] gnt_c;
  logic [NUM_REQ-1:0] rvalid_d;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [ADDR_W-1:0]  rom_addr_q;
  logic [DATA_W-1:0]  rdata_c;
  logic               busy_c;
  tag_t               tag_q [ROM_LAT];

  // Winner search: first requester above the pointer, wrapping; player pre-empts when prioritised.
  always_comb begin
    hit_c     = 1'b0;
    win_c     = '0;
    cand_c    = '0;
    ptr_upd_c = 1'b0;
    if (reset_n && bus.en) begin
`ifdef SPRITE_ARB_PRIO_EN
      hit_c = bus.req[0];
`else
      hit_c = 1'b0;
`endif
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand_c = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
        if (!hit_c && bus.req[cand_c]) begin
          hit_c     = 1'b1;
          win_c     = cand_c;
          ptr_upd_c = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_c = '0;
    if (hit_c) gnt_c[win_c] = 1'b1;
  end

  // Tag leaving the last stage lines up with rom_q for that read.
  always_comb begin
    rvalid_d = '0;
    if (tag_q[ROM_LAT-1].vld) rvalid_d[tag_q[ROM_LAT-1].id] = 1'b1;
  end

  always_comb begin
    busy_c = 1'b0;
    for (int unsigned s = 0; s < ROM_LAT; s++) busy_c = busy_c | tag_q[s].vld;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= PTR_RST;
      rom_addr_q <= '0;
      rvalid_q   <= '0;
      for (int unsigned s = 0; s < ROM_LAT; s++) tag_q[s] <= '0;
    end else begin
      if (hit_c) rom_addr_q <= bus.addr_flat[32'(win_c)*ADDR_W +: ADDR_W];
      if (ptr_upd_c) ptr_q <= win_c;
      tag_q[0] <= tag_t'{vld: hit_c, id: win_c};
      for (int unsigned s = 1; s < ROM_LAT; s++) tag_q[s] <= tag_q[s-1];
      rvalid_q <= rvalid_d;
    end
  end

  assign rdata_c      = bus.rom_q;
  assign bus.gnt      = gnt_c;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rdata    = rdata_c;
  assign bus.rvalid   = rvalid_q;
  assign bus.busy     = busy_c;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
`timescale 1ns/1ps
// Randomised self-checking bench for sprite_rom_arbiter against a transaction-level reference model.
module tb_sprite_rom_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DATA_W  = 4;
  localparam int unsigned ROM_LAT = 1;
`ifdef SPRITE_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)) dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [DATA_W-1:0] rom_val(input logic [ADDR_W-1:0] a);
    return DATA_W'(a ^ (a >> 4) ^ (a >> 7) ^ ADDR_W'(3));
  endfunction

  // Synchronous ROM with ROM_LAT cycles of read latency.
  logic [DATA_W-1:0] q_pipe [ROM_LAT];
  always @(posedge vga_clk) begin
    q_pipe[0] <= rom_val(bus.rom_addr);
    for (int s = 1; s < ROM_LAT; s++) q_pipe[s] <= q_pipe[s-1];
  end
  assign bus.rom_q = q_pipe[ROM_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one history entry per clock of what was granted.
  typedef struct { bit v; int id; int addr; } rd_t;
  rd_t hist[$];
  int  m_ptr;
  int  m_raddr;
  bit  pend;
  int  exp_win;
  int  exp_waddr;
  logic [NUM_REQ-1:0] exp_gnt;
  logic [NUM_REQ-1:0] exp_rvalid;
  logic [DATA_W-1:0]  exp_rdata;
  logic               exp_busy;
  logic [ADDR_W-1:0]  exp_raddr;

  task automatic model_reset();
    hist.delete();
    m_ptr   = NUM_REQ - 1;
    m_raddr = 0;
    pend    = 1'b0;
    exp_win = -1;
  endtask

  // Advance one clock, drive inputs at the falling edge, then derive expected outputs.
  task automatic step(input logic e, input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*ADDR_W-1:0] a);
    rd_t ent;
    int  best, d, n;
    @(posedge vga_clk);
    if (pend) begin
      ent.v    = (exp_win >= 0);
      ent.id   = exp_win;
      ent.addr = exp_waddr;
      hist.push_back(ent);
      if (hist.size() > ROM_LAT + 1) void'(hist.pop_front());
      if (ent.v) begin
        m_raddr = ent.addr;
        if (!(PRIO && ent.id == 0)) m_ptr = ent.id;
      end
    end
    @(negedge vga_clk);
    bus.en = e; bus.req = r; bus.addr_flat = a;
    #1;
    exp_win = -1;
    best    = NUM_REQ;
    if (reset_n && e && r != '0) begin
      if (PRIO && r[0]) exp_win = 0;
      else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (r[i]) begin
            d = (i - m_ptr - 1 + 2 * NUM_REQ) % NUM_REQ;
            if (d < best) begin best = d; exp_win = i; end
          end
        end
      end
    end
    exp_gnt   = '0;
    exp_waddr = 0;
    if (exp_win >= 0) begin
      exp_gnt[exp_win] = 1'b1;
      exp_waddr = int'(a[exp_win*ADDR_W +: ADDR_W]);
    end
    n = hist.size();
    exp_rvalid = '0;
    exp_rdata  = '0;
    if (n >= ROM_LAT + 1 && hist[n-1-ROM_LAT].v) begin
      exp_rvalid[hist[n-1-ROM_LAT].id] = 1'b1;
      exp_rdata = rom_val(ADDR_W'(hist[n-1-ROM_LAT].addr));
    end
    exp_busy = 1'b0;
    for (int j = n - ROM_LAT; j < n; j++) if (j >= 0 && hist[j].v) exp_busy = 1'b1;
    exp_raddr = ADDR_W'(m_raddr);
    pend = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge vga_clk);
    reset_n = 1'b0; bus.en = 1'b0; bus.req = '0; bus.addr_flat = '0;
    model_reset();
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [NUM_REQ*ADDR_W-1:0] rand_addrs();
    logic [NUM_REQ*ADDR_W-1:0] a;
    for (int i = 0; i < NUM_REQ; i++) a[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
    return a;
  endfunction

  task automatic test_reset();
    @(negedge vga_clk);
    reset_n = 1'b0; bus.en = 1'b1; bus.req = 4'hF; bus.addr_flat = rand_addrs();
    model_reset();
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
      n_checks++; if (bus.rvalid !== 4'b0000) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0000", bus.rvalid); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      n_checks++; if (bus.rom_addr !== 10'h000) begin n_fail++; $display("FAIL reset_rom_addr: got %h expected 000", bus.rom_addr); end
      @(negedge vga_clk);
    end
    bus.en = 1'b0; bus.req = '0;
    reset_n = 1'b1;
    step(1'b1, 4'hF, rand_addrs());
    n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt: got %b expected 0001", bus.gnt); end
    n_checks++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL reset_first_gnt_model: got %b expected %b", bus.gnt, exp_gnt); end
  endtask

  task automatic test_single();
    logic [NUM_REQ*ADDR_W-1:0] a;
    apply_reset();
    a = rand_addrs();
    a[2*ADDR_W +: ADDR_W] = 10'h155;
    step(1'b1, 4'b0100, a);
    n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b expected 0100", bus.gnt); end
    step(1'b1, 4'b0000, a);
    n_checks++; if (bus.rom_addr !== 10'h155) begin n_fail++; $display("FAIL single_rom_addr: got %h expected 155", bus.rom_addr); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
    n_checks++; if (bus.rvalid !== 4'b0000) begin n_fail++; $display("FAIL single_rvalid_early: got %b expected 0000", bus.rvalid); end
    step(1'b1, 4'b0000, a);
    n_checks++; if (bus.rvalid !== 4'b0100) begin n_fail++; $display("FAIL single_rvalid: got %b expected 0100", bus.rvalid); end
    n_checks++; if (bus.rdata !== rom_val(10'h155)) begin n_fail++; $display("FAIL single_rdata: got %h expected %h", bus.rdata, rom_val(10'h155)); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_done: got %b expected 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [NUM_REQ-1:0] exp_seq;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, (k < 8) ? 4'hF : 4'h0, rand_addrs());
      n_checks++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, bus.gnt, exp_gnt); end
      n_checks++; if (bus.rvalid !== exp_rvalid) begin n_fail++; $display("FAIL b2b_rvalid[%0d]: got %b expected %b", k, bus.rvalid, exp_rvalid); end
      if (exp_rvalid != '0) begin
        n_checks++; if (bus.rdata !== exp_rdata) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", k, bus.rdata, exp_rdata); end
      end
`ifndef SPRITE_ARB_PRIO_EN
      exp_seq = '0; exp_seq[k % 4] = 1'b1;
      if (k < 8) begin
        n_checks++; if (bus.gnt !== exp_seq) begin n_fail++; $display("FAIL b2b_gnt_order[%0d]: got %b expected %b", k, bus.gnt, exp_seq); end
      end
      exp_seq = '0; exp_seq[(k + 2) % 4] = 1'b1;
      if (k >= 2) begin
        n_checks++; if (bus.rvalid !== exp_seq) begin n_fail++; $display("FAIL b2b_rvalid_order[%0d]: got %b expected %b", k, bus.rvalid, exp_seq); end
      end
`endif
    end
  endtask

  task automatic test_en_drop();
    int seen = 0;
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      step(k < 2, 4'hF, rand_addrs());
      if (bus.rvalid != '0) seen++;
      n_checks++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL endrop_gnt[%0d]: got %b expected %b", k, bus.gnt, exp_gnt); end
      if (k >= 2) begin
        n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL endrop_gnt_off[%0d]: got %b expected 0000", k, bus.gnt); end
      end
      n_checks++; if (bus.rvalid !== exp_rvalid) begin n_fail++; $display("FAIL endrop_rvalid[%0d]: got %b expected %b", k, bus.rvalid, exp_rvalid); end
      n_checks++; if (bus.busy !== exp_busy) begin n_fail++; $display("FAIL endrop_busy[%0d]: got %b expected %b", k, bus.busy, exp_busy); end
    end
    n_checks++; if (seen != 2) begin n_fail++; $display("FAIL endrop_returns: got %0d expected 2", seen); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL endrop_busy_final: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    logic [NUM_REQ*ADDR_W-1:0] a;
    apply_reset();
    a = rand_addrs();
    step(1'b1, 4'b0010, a);
    n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL rstmid_gnt: got %b expected 0010", bus.gnt); end
    step(1'b1, 4'b0000, a);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 1", bus.busy); end
    n_checks++; if (bus.rom_addr !== a[ADDR_W +: ADDR_W]) begin n_fail++; $display("FAIL rstmid_rom_addr: got %h expected %h", bus.rom_addr, a[ADDR_W +: ADDR_W]); end
    reset_n = 1'b0; bus.en = 1'b0; bus.req = '0;
    model_reset();
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_clr: got %b expected 0", bus.busy); end
    n_checks++; if (bus.rom_addr !== 10'h000) begin n_fail++; $display("FAIL rstmid_rom_addr_clr: got %h expected 000", bus.rom_addr); end
    @(negedge vga_clk);
    #1;
    n_checks++; if (bus.rvalid !== 4'b0000) begin n_fail++; $display("FAIL rstmid_rvalid_dropped: got %b expected 0000", bus.rvalid); end
    reset_n = 1'b1;
    step(1'b1, 4'hF, rand_addrs());
    n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL rstmid_ptr: got %b expected 0001", bus.gnt); end
    n_checks++; if (bus.rvalid !== 4'b0000) begin n_fail++; $display("FAIL rstmid_rvalid_after: got %b expected 0000", bus.rvalid); end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0]         ra [NUM_REQ];
    logic [NUM_REQ-1:0]        rq;
    logic [NUM_REQ*ADDR_W-1:0] a;
    logic                      e;
    apply_reset();
    rq = '0;
    for (int i = 0; i < NUM_REQ; i++) ra[i] = ADDR_W'($urandom);
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!rq[i] && $urandom_range(0, 2) == 0) begin rq[i] = 1'b1; ra[i] = ADDR_W'($urandom); end
        a[i*ADDR_W +: ADDR_W] = ra[i];
      end
      e = ($urandom_range(0, 7) != 0);
      step(e, rq, a);
      n_checks++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL rand_gnt[%0d]: got %b expected %b", k, bus.gnt, exp_gnt); end
      n_checks++; if (bus.rvalid !== exp_rvalid) begin n_fail++; $display("FAIL rand_rvalid[%0d]: got %b expected %b", k, bus.rvalid, exp_rvalid); end
      n_checks++; if (bus.busy !== exp_busy) begin n_fail++; $display("FAIL rand_busy[%0d]: got %b expected %b", k, bus.busy, exp_busy); end
      n_checks++; if (bus.rom_addr !== exp_raddr) begin n_fail++; $display("FAIL rand_rom_addr[%0d]: got %h expected %h", k, bus.rom_addr, exp_raddr); end
      if (exp_rvalid != '0) begin
        n_checks++; if (bus.rdata !== exp_rdata) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h expected %h", k, bus.rdata, exp_rdata); end
      end
      if (exp_win >= 0) begin
        if ($urandom_range(0, 1) == 0) rq[exp_win] = 1'b0;
        else ra[exp_win] = ADDR_W'($urandom);
      end
    end
  endtask

`ifdef SPRITE_ARB_PRIO_EN
  task automatic test_prio();
    logic [NUM_REQ-1:0] exp_seq;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'hF, rand_addrs());
      n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL prio_gnt0[%0d]: got %b expected 0001", k, bus.gnt); end
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 4'hE, rand_addrs());
      exp_seq = '0; exp_seq[(k % 3) + 1] = 1'b1;
      n_checks++; if (bus.gnt !== exp_seq) begin n_fail++; $display("FAIL prio_rr[%0d]: got %b expected %b", k, bus.gnt, exp_seq); end
      n_checks++; if (bus.rvalid !== exp_rvalid) begin n_fail++; $display("FAIL prio_rvalid[%0d]: got %b expected %b", k, bus.rvalid, exp_rvalid); end
    end
  endtask
`endif

  initial begin
    bus.en = 1'b0; bus.req = '0; bus.addr_flat = '0;
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_random();
`ifdef SPRITE_ARB_PRIO_EN
    test_prio();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
